// File: rtl/vram_arbiter_pkg.sv
// Shared graphite definitions for the VRAM arbiter: FSM state encoding and
// requester index constants.
package vram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUS  = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

  localparam logic REQ_GFX  = 1'b0;
  localparam logic REQ_HOST = 1'b1;

endpackage

// File: rtl/vram_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick: a lone requester wins outright,
// and on contention the requester that was not granted last time wins.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_valid_o,
  output logic       grant_idx_o
);

  always_comb begin
    grant_valid_o = |req_i;
    if (&req_i) grant_idx_o = ~last_grant_i;
    else        grant_idx_o = req_i[1];
  end

endmodule

// File: rtl/vram_arbiter.sv
// Two-requester VRAM port arbiter: grants one whole transaction at a time,
// drives the VRAM bus, and returns ack/err/read data to the granted requester.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int MASK_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset_i,
  input  logic [1:0]              req_sel_i,
  input  logic [1:0]              req_wr_i,
  input  logic [2*MASK_WIDTH-1:0] req_mask_i,
  input  logic [2*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [2*DATA_WIDTH-1:0] req_data_i,
  output logic [1:0]              req_ack_o,
  output logic [1:0]              req_err_o,
  output logic [DATA_WIDTH-1:0]   req_data_o,
  input  logic                    vram_ack_i,
  input  logic [DATA_WIDTH-1:0]   vram_data_in_i,
  output logic                    vram_sel_o,
  output logic                    vram_wr_o,
  output logic [MASK_WIDTH-1:0]   vram_mask_o,
  output logic [ADDR_WIDTH-1:0]   vram_addr_o,
  output logic [DATA_WIDTH-1:0]   vram_data_out_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sel_q, sel_d, wr_q, wr_d;
  logic [MASK_WIDTH-1:0] mask_q, mask_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]            ack_q, ack_d, err_q, err_d;
  logic                  grant_valid, grant_idx;
  logic [1:0]            grant_onehot;

  rr_arbiter2 u_rr (
    .req_i         (req_sel_i),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  // last_grant_q doubles as the owner of the in-flight transaction
  assign grant_onehot = (last_grant_q == REQ_HOST) ? 2'b10 : 2'b01;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    wr_d         = wr_q;
    mask_d       = mask_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    ack_d        = 2'b00;
    err_d        = 2'b00;
    case (state_q)
      ARB_IDLE: begin
        if (grant_valid) begin
          state_d      = ARB_BUS;
          last_grant_d = grant_idx;
          cnt_d        = '0;
          sel_d        = 1'b1;
          wr_d         = req_wr_i[grant_idx];
          mask_d       = grant_idx ? req_mask_i[2*MASK_WIDTH-1:MASK_WIDTH] : req_mask_i[MASK_WIDTH-1:0];
          addr_d       = grant_idx ? req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr_i[ADDR_WIDTH-1:0];
          wdata_d      = grant_idx ? req_data_i[2*DATA_WIDTH-1:DATA_WIDTH] : req_data_i[DATA_WIDTH-1:0];
        end
      end
      ARB_BUS: begin
        if (vram_ack_i) begin
          state_d = ARB_DONE;
          sel_d   = 1'b0;
          wr_d    = 1'b0;
          ack_d   = grant_onehot;
          if (!wr_q) rdata_d = vram_data_in_i;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ARB_DONE;
          sel_d   = 1'b0;
          wr_d    = 1'b0;
          ack_d   = grant_onehot;
          err_d   = grant_onehot;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= REQ_HOST;
      cnt_q        <= '0;
      sel_q        <= 1'b0;
      wr_q         <= 1'b0;
      mask_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      ack_q        <= 2'b00;
      err_q        <= 2'b00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      wr_q         <= wr_d;
      mask_q       <= mask_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
    end
  end

  assign req_ack_o       = ack_q;
  assign req_err_o       = err_q;
  assign req_data_o      = rdata_q;
  assign vram_sel_o      = sel_q;
  assign vram_wr_o       = wr_q;
  assign vram_mask_o     = mask_q;
  assign vram_addr_o     = addr_q;
  assign vram_data_out_o = wdata_q;

endmodule
